// File: rtl/btb_pkg.sv
// Types shared by the branch target buffer and its write-side update queue.
package btb_pkg;

  localparam int PC_W  = 29;
  localparam int TGT_W = 30;

  typedef enum logic [1:0] {
    BT_NONE = 2'b00,
    BT_COND = 2'b01,
    BT_JUMP = 2'b10,
    BT_RET  = 2'b11
  } btype_t;

  typedef struct packed {
    logic [PC_W-1:0]  PC;
    logic [TGT_W-1:0] target;
    btype_t           btype;
  } btb_update_t;

endpackage

// File: rtl/btb_update_queue.sv
// Filters resolved branches down to BTB mispredicts, queues them with same-PC
// tail coalescing, and drains one entry per cycle into the BTB load port.
module btb_update_queue
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [PC_W-1:0]          res_PC,
  input  logic [TGT_W-1:0]         res_target,
  input  logic [1:0]               res_btype,
  input  logic                     res_taken,
  input  logic                     res_pred_hit,
  input  logic [TGT_W-1:0]         res_pred_target,
  input  logic                     btb_stall,
  output logic [PC_W-1:0]          new_PC,
  output logic [TGT_W-1:0]         new_target,
  output logic [1:0]               new_btype,
  output logic                     load,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Handshake: a branch is taken on any rising edge with res_valid && res_ready;
  // res_ready depends only on occupancy, never on the res_* payload.

  btb_update_t      mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] tail_last;
  logic [OCC_W-1:0] occ;

  logic        full;
  logic        accept;
  logic        need_update;
  logic        tail_match;
  logic        coalesce;
  logic        push;
  logic        pop;
  btb_update_t head;
  btb_update_t incoming;

  assign full        = (occ == OCC_W'(DEPTH));
  assign res_ready   = !full;
  assign occupancy   = occ;

  assign accept      = res_valid && res_ready;
  assign need_update = res_taken && (!res_pred_hit || (res_pred_target != res_target));
  assign tail_last   = tail_ptr - PTR_W'(1);
  assign tail_match  = (occ != '0) && (mem[tail_last].PC == res_PC);

  assign pop         = (occ != '0) && !btb_stall;
  // A lone entry leaving this cycle cannot absorb the update; it becomes a new entry.
  assign coalesce    = accept && need_update && tail_match &&
                       !((occ == OCC_W'(1)) && pop);
  assign push        = accept && need_update && !coalesce;

  assign incoming.PC     = res_PC;
  assign incoming.target = res_target;
  assign incoming.btype  = btype_t'(res_btype);

  assign head       = mem[head_ptr];
  assign load       = pop;
  assign new_PC     = (occ != '0) ? head.PC     : '0;
  assign new_target = (occ != '0) ? head.target : '0;
  assign new_btype  = (occ != '0) ? head.btype  : BT_NONE;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_ptr] <= incoming;
    end else if (coalesce) begin
      mem[tail_last].target <= incoming.target;
      mem[tail_last].btype  <= incoming.btype;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      occ      <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Bench for btb_update_queue: directed scenarios plus randomized traffic
// checked against a queue-based model of the update stream.
module tb_btb_update_queue;

  localparam int DEPTH = 4;
  localparam int W     = 61;

  logic        clk;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [28:0] res_PC;
  logic [29:0] res_target;
  logic [1:0]  res_btype;
  logic        res_taken;
  logic        res_pred_hit;
  logic [29:0] res_pred_target;
  logic        btb_stall;
  logic [28:0] new_PC;
  logic [29:0] new_target;
  logic [1:0]  new_btype;
  logic        load;
  logic [2:0]  occupancy;

  int total;
  int bad;

  // Entries are {PC[60:32], target[31:2], btype[1:0]}.
  logic [W-1:0] exp_q[$];

  btb_update_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_PC(res_PC),
    .res_target(res_target),
    .res_btype(res_btype),
    .res_taken(res_taken),
    .res_pred_hit(res_pred_hit),
    .res_pred_target(res_pred_target),
    .btb_stall(btb_stall),
    .new_PC(new_PC),
    .new_target(new_target),
    .new_btype(new_btype),
    .load(load),
    .occupancy(occupancy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_branch(input logic [28:0] pc, input logic [29:0] tgt,
                              input logic taken, input logic hit,
                              input logic [29:0] pred, input logic [1:0] bt);
    res_valid       = 1'b1;
    res_PC          = pc;
    res_target      = tgt;
    res_taken       = taken;
    res_pred_hit    = hit;
    res_pred_target = pred;
    res_btype       = bt;
  endtask

  task automatic drive_idle();
    res_valid       = 1'b0;
    res_PC          = '0;
    res_target      = '0;
    res_taken       = 1'b0;
    res_pred_hit    = 1'b0;
    res_pred_target = '0;
    res_btype       = 2'b00;
  endtask

  // Advances one clock; the model applies the rules to the inputs seen at the edge.
  task automatic tick();
    int           n;
    logic         pop;
    logic         acc;
    logic         need;
    logic         do_push;
    logic [W-1:0] ent;
    @(posedge clk);
    n = exp_q.size();
    if (!rst) begin
      exp_q.delete();
    end else begin
      pop     = (n != 0) && !btb_stall;
      acc     = res_valid && (n < DEPTH);
      need    = res_taken && (!res_pred_hit || (res_pred_target != res_target));
      ent     = {res_PC, res_target, res_btype};
      do_push = 1'b0;
      if (acc && need) begin
        if (n >= 1 && exp_q[n-1][60:32] == res_PC && !(n == 1 && pop))
          exp_q[n-1] = ent;
        else
          do_push = 1'b1;
      end
      if (pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ent);
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    btb_stall = 1'b0;
    drive_idle();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (load !== 1'b0 || occupancy !== 3'd0 || res_ready !== 1'b1 ||
          new_PC !== '0 || new_target !== '0 || new_btype !== 2'b00) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d load=%b occ=%0d ready=%b pc=%h tgt=%h bt=%b want 0/0/1/0/0/0",
                 i, load, occupancy, res_ready, new_PC, new_target, new_btype);
      end
      tick();
    end
  endtask

  task automatic test_filter();
    btb_stall = 1'b0;
    drive_branch(29'h50, 30'h100, 1'b1, 1'b1, 30'h100, 2'b01);
    tick();
    drive_idle();
    #1;
    total++;
    if (load !== 1'b0 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL filter_discard load=%b occ=%0d want 0/0", load, occupancy);
    end
    drive_branch(29'h10, 30'h200, 1'b1, 1'b0, 30'h0, 2'b10);
    tick();
    drive_idle();
    #1;
    total++;
    if (load !== 1'b1 || new_PC !== 29'h10 || new_target !== 30'h200 || new_btype !== 2'b10) begin
      bad++;
      $display("FAIL filter_miss load=%b pc=%h tgt=%h bt=%b want 1/10/200/10", load, new_PC, new_target, new_btype);
    end
    tick();
    #1;
    total++;
    if (load !== 1'b0 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL filter_drained load=%b occ=%0d want 0/0", load, occupancy);
    end
  endtask

  task automatic test_fill_stall();
    btb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_branch(29'(i), 30'(32'h40 + i), 1'b1, 1'b0, 30'h0, 2'b01);
      tick();
    end
    drive_branch(29'h5, 30'h45, 1'b1, 1'b0, 30'h0, 2'b01);
    #1;
    total++;
    if (occupancy !== 3'd4 || res_ready !== 1'b0 || load !== 1'b0) begin
      bad++;
      $display("FAIL fill_full occ=%0d ready=%b load=%b want 4/0/0", occupancy, res_ready, load);
    end
    tick();
    drive_idle();
    btb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++;
      if (load !== 1'b1 || new_PC !== 29'(i) || new_target !== 30'(32'h40 + i)) begin
        bad++;
        $display("FAIL fill_drain idx=%0d load=%b pc=%h tgt=%h want 1/%h/%h", i, load, new_PC, new_target, i, 32'h40 + i);
      end
      tick();
    end
    #1;
    total++;
    if (load !== 1'b0 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL fill_after load=%b occ=%0d want 0/0 (fifth branch must be rejected)", load, occupancy);
    end
  endtask

  task automatic test_coalesce();
    btb_stall = 1'b1;
    drive_branch(29'h20, 30'hA0, 1'b1, 1'b0, 30'h0, 2'b01);
    tick();
    drive_branch(29'h20, 30'hB0, 1'b1, 1'b1, 30'hA0, 2'b10);
    tick();
    drive_idle();
    #1;
    total++;
    if (occupancy !== 3'd1 || new_target !== 30'hB0 || new_btype !== 2'b10) begin
      bad++;
      $display("FAIL coalesce_occ occ=%0d tgt=%h bt=%b want 1/b0/10", occupancy, new_target, new_btype);
    end
    btb_stall = 1'b0;
    #1;
    total++;
    if (load !== 1'b1 || new_PC !== 29'h20 || new_target !== 30'hB0) begin
      bad++;
      $display("FAIL coalesce_load load=%b pc=%h tgt=%h want 1/20/b0", load, new_PC, new_target);
    end
    tick();
    #1;
    total++;
    if (load !== 1'b0 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL coalesce_single load=%b occ=%0d want 0/0", load, occupancy);
    end
  endtask

  task automatic test_coalesce_race();
    btb_stall = 1'b0;
    drive_branch(29'h30, 30'hA0, 1'b1, 1'b0, 30'h0, 2'b01);
    tick();
    drive_branch(29'h30, 30'hC0, 1'b1, 1'b0, 30'h0, 2'b11);
    #1;
    total++;
    if (load !== 1'b1 || new_target !== 30'hA0) begin
      bad++;
      $display("FAIL race_head load=%b tgt=%h want 1/a0", load, new_target);
    end
    tick();
    drive_idle();
    #1;
    total++;
    if (occupancy !== 3'd1 || load !== 1'b1 || new_PC !== 29'h30 || new_target !== 30'hC0 || new_btype !== 2'b11) begin
      bad++;
      $display("FAIL race_new occ=%0d load=%b pc=%h tgt=%h bt=%b want 1/1/30/c0/11",
               occupancy, load, new_PC, new_target, new_btype);
    end
    tick();
    #1;
    total++;
    if (occupancy !== 3'd0) begin
      bad++;
      $display("FAIL race_empty occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] h;
    logic         e_load;
    logic [2:0]   e_occ;
    for (int c = 0; c < 400; c++) begin
      btb_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        res_valid       = 1'b1;
        res_PC          = 29'($urandom_range(0, 3));
        res_target      = 30'($urandom_range(0, 7) << 4);
        res_taken       = ($urandom_range(0, 4) != 0);
        res_pred_hit    = $urandom_range(0, 1);
        res_pred_target = ($urandom_range(0, 1) != 0) ? res_target : 30'($urandom_range(0, 7) << 4);
        res_btype       = 2'($urandom_range(0, 3));
      end else begin
        drive_idle();
      end
      #1;
      e_occ  = 3'(exp_q.size());
      e_load = (exp_q.size() != 0) && !btb_stall;
      h      = (exp_q.size() != 0) ? exp_q[0] : '0;
      total++;
      if (load !== e_load || occupancy !== e_occ || res_ready !== (exp_q.size() != DEPTH) ||
          new_PC !== h[60:32] || new_target !== h[31:2] || new_btype !== h[1:0]) begin
        bad++;
        $display("FAIL random cyc=%0d load=%b occ=%0d rdy=%b pc=%h tgt=%h bt=%b want %b/%0d/%b/%h/%h/%b",
                 c, load, occupancy, res_ready, new_PC, new_target, new_btype,
                 e_load, e_occ, exp_q.size() != DEPTH, h[60:32], h[31:2], h[1:0]);
      end
      tick();
    end
    drive_idle();
    btb_stall = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  task automatic test_async_reset();
    btb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_branch(29'(32'h60 + i), 30'(32'h300 + i), 1'b1, 1'b0, 30'h0, 2'b01);
      tick();
    end
    drive_idle();
    #1;
    total++;
    if (occupancy !== 3'd3) begin
      bad++;
      $display("FAIL areset_pre occ=%0d want 3", occupancy);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (occupancy !== 3'd0 || load !== 1'b0 || res_ready !== 1'b1 ||
        new_PC !== '0 || new_target !== '0 || new_btype !== 2'b00) begin
      bad++;
      $display("FAIL areset_now occ=%0d load=%b rdy=%b pc=%h tgt=%h bt=%b want 0/0/1/0/0/0",
               occupancy, load, res_ready, new_PC, new_target, new_btype);
    end
    tick();
    rst = 1'b1;
    btb_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (load !== 1'b0 || occupancy !== 3'd0) begin
        bad++;
        $display("FAIL areset_stale cyc=%0d load=%b occ=%0d want 0/0", i, load, occupancy);
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_filter();
    test_fill_stall();
    test_coalesce();
    test_coalesce_race();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Write-side companion to the branch target buffer. Accepts resolved branches from execute and keeps only those the BTB mispredicted. Buffers them in a small FIFO, merging back-to-back updates to the same PC. Drains one entry per cycle into the BTB load port (`new_PC`, `new_target`, `new_btype`, `load`) whenever the BTB is not busy with fetch.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `res_valid`, input, 1: execute presents a resolved branch.
- `res_ready`, output, 1: queue can accept a branch; equals `!full`.
- `res_PC`, input, 29: fetch-block PC of the branch.
- `res_target`, input, 30: resolved target.
- `res_btype`, input, 2: branch type (`btype_t`).
- `res_taken`, input, 1: branch resolved taken.
- `res_pred_hit`, input, 1: BTB hit at fetch time.
- `res_pred_target`, input, 30: target the BTB supplied at fetch.
- `btb_stall`, input, 1: BTB port busy this cycle; hold the head.
- `new_PC`, output, 29: head entry PC; 0 when empty.
- `new_target`, output, 30: head entry target; 0 when empty.
- `new_btype`, output, 2: head entry type; `BT_NONE` when empty.
- `load`, output, 1: write strobe to the BTB.
- `occupancy`, output, $clog2(DEPTH)+1: current entry count.

## Operation
- Accept: `res_valid && res_ready` on a clock edge.
- Update needed: `res_taken && (!res_pred_hit || res_pred_target != res_target)`. Accepted branches that fail this test are consumed and discarded; state is unchanged.
- Coalesce:
  - Applies when an update is needed and `occupancy ≥ 1` and `res_PC` equals the tail entry's PC.
  - The tail's target and btype are overwritten; no new entry is added.
  - Exception: if `occupancy == 1` and the tail is popped the same cycle, the branch is pushed as a new entry instead.
- Push: otherwise, write at the tail pointer and increment the tail.
- Drain: `load = (occupancy != 0) && !btb_stall`. The head is popped on any edge where `load` is high. `new_*` are driven combinationally from head storage.
- Simultaneous push and pop: legal whenever `!full`. Occupancy is unchanged.
- Full: `res_ready` low, even if a pop occurs that cycle. `res_ready` never depends on `res_*` data.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `occupancy` is a separate counter in the range 0..DEPTH.
- `btype` encoding: 00 `BT_NONE`, 01 `BT_COND`, 10 `BT_JUMP`, 11 `BT_RET`.

## Timing
- Reset (`rst` low, asynchronous):
  - Pointers and `occupancy` go to 0.
  - `load` goes to 0 and `res_ready` to 1.
  - `new_PC`, `new_target` go to 0; `new_btype` goes to `BT_NONE`.
  - Storage contents are don't-care.
- Reset mid-operation drops all pending entries; no `load` is issued for them.
- Latency: a branch accepted at edge N can appear with `load` high in the cycle after edge N at the earliest.
- Throughput: one accept and one drain per cycle.
- Stall: while `btb_stall` is high, `load` is 0 and `new_*` hold the head value unchanged.
- Coalesce on the tail: changes only the tail entry. A head that is not the tail is unaffected.
- Coalesce when head == tail and the head is not being popped: updated `new_*` are visible the next cycle.

## Structure
- Shared package `btb_pkg`, which `branch_target_buffer` also imports:
  - `PC_W = 29`, `TGT_W = 30`.
  - `typedef enum logic [1:0] btype_t`.
  - `btb_update_t` packed struct with fields `PC`, `target`, `btype`.
- No sub-module. Storage, pointers and the coalesce compare live in this module, because coalescing needs tail read/write access that a generic FIFO does not provide.

## Test plan
- Reset then idle: after reset release, `load` = 0, `occupancy` = 0, `res_ready` = 1 and `new_*` = 0 for 10 cycles.
- Filter: push taken, hit, `pred_target == target` = 0x100 → discarded, no `load`. Push taken, miss, PC 0x10, target 0x200 → next cycle `load` = 1 with `new_PC` = 0x10, `new_target` = 0x200.
- Fill under stall:
  - With `btb_stall` = 1, push PCs 0x1..0x4 (all mispredicts). `occupancy` reaches 4, `res_ready` = 0, a fifth valid branch is not accepted.
  - Release the stall: loads appear in order 0x1..0x4 on 4 consecutive cycles, then `load` = 0.
- Coalesce: with `btb_stall` = 1, push PC 0x20/target 0xA0, then PC 0x20/target 0xB0. `occupancy` = 1; after release, a single `load` with `new_target` = 0xB0.
- Coalesce race: `occupancy` = 1 (PC 0x30), no stall, push PC 0x30/target 0xC0 in the cycle the head pops. `occupancy` = 1 afterwards, and the next `load` carries 0xC0.
- Async reset with 3 entries queued and `btb_stall` = 1: drive `rst` low mid-cycle → `occupancy`, `load` and `new_*` clear immediately, and no stale load follows release.
